// File: rtl/vga_timing_ctrl_if.sv
// Pixel request bus between the VGA timing stage (master) and the upstream pixel source (slave).
interface vga_timing_ctrl_if;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        pixel_req;
  logic [23:0] rgb_in;

  modport master (output pixel_x, output pixel_y, output pixel_req, input rgb_in);
  modport slave  (input pixel_x, input pixel_y, input pixel_req, output rgb_in);
endinterface

// File: rtl/vga_timing_ctrl.sv
// 640x480@60 VGA timing generator: divides clk by two into a pixel tick, issues coordinates
// upstream and registers colour, sync and blank together so all DAC pins change on one edge.
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIX_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_ctrl_if.master pix_bus,
  output logic              o_hSync,
  output logic              o_vSync,
  output logic [7:0]        o_red,
  output logic [7:0]        o_green,
  output logic [7:0]        o_blue,
  output logic              o_syncN,
  output logic              o_clk,
  output logic              o_blank,
  output logic              o_frameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1};

  logic        r_pixEn;
  logic        w_tick;
  logic [9:0]  r_hCnt;
  logic [9:0]  r_vCnt;
  logic        w_hAtMax;
  logic        w_vAtMax;
  ctl_t        w_raw;
  ctl_t        w_tail;
  logic        r_hSync;
  logic        r_vSync;
  logic        r_blank;
  logic [23:0] r_rgb;
  logic        r_frameStart;

  // Pixel enable toggles every clk; the edge where it is high is the pixel tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pixEn <= 1'b0;
    end else begin
      r_pixEn <= ~r_pixEn;
    end
  end

  assign w_tick   = r_pixEn;
  assign w_hAtMax = (r_hCnt == H_MAX);
  assign w_vAtMax = (r_vCnt == V_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hCnt <= 10'd0;
      r_vCnt <= 10'd0;
    end else if (w_tick) begin
      if (w_hAtMax) begin
        r_hCnt <= 10'd0;
        if (w_vAtMax) begin
          r_vCnt <= 10'd0;
        end else begin
          r_vCnt <= r_vCnt + 10'd1;
        end
      end else begin
        r_hCnt <= r_hCnt + 10'd1;
      end
    end
  end

  assign w_raw.active = (r_hCnt < H_ACT_END) && (r_vCnt < V_ACT_END);
  assign w_raw.hs     = !((r_hCnt >= HS_FIRST) && (r_hCnt <= HS_LAST));
  assign w_raw.vs     = !((r_vCnt >= VS_FIRST) && (r_vCnt <= VS_LAST));

  assign pix_bus.pixel_x   = r_hCnt;
  assign pix_bus.pixel_y   = r_vCnt;
  assign pix_bus.pixel_req = w_raw.active;

  // Control bits wait PIX_LAT ticks so they meet the colour returned for the same coordinate.
  generate
    if (PIX_LAT == 0) begin : g_noDelay
      assign w_tail = w_raw;
    end else begin : g_delay
      ctl_t r_dly [PIX_LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIX_LAT; i++) begin
            r_dly[i] <= CTL_IDLE;
          end
        end else if (w_tick) begin
          r_dly[0] <= w_raw;
          for (int i = 1; i < PIX_LAT; i++) begin
            r_dly[i] <= r_dly[i-1];
          end
        end
      end

      assign w_tail = r_dly[PIX_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hSync <= 1'b1;
      r_vSync <= 1'b1;
      r_blank <= 1'b0;
      r_rgb   <= 24'h0;
    end else if (w_tick) begin
      r_hSync <= w_tail.hs;
      r_vSync <= w_tail.vs;
      r_blank <= w_tail.active;
      r_rgb   <= w_tail.active ? pix_bus.rgb_in : 24'h0;
    end
  end

  // High only for the clk after the tick that wraps both counters; the next edge is never a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frameStart <= 1'b0;
    end else begin
      r_frameStart <= w_tick && w_hAtMax && w_vAtMax;
    end
  end

  assign o_hSync      = r_hSync;
  assign o_vSync      = r_vSync;
  assign o_red        = r_rgb[23:16];
  assign o_green      = r_rgb[15:8];
  assign o_blue       = r_rgb[7:0];
  assign o_syncN      = 1'b0;
  assign o_clk        = r_pixEn;
  assign o_blank      = r_blank;
  assign o_frameStart = r_frameStart;

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Display timing and pixel-output stage that drives the VGA DAC pins of the top level (h_sync, v_sync, 8-bit red/green/blue, sync_n, clk_out, blank). It divides the 50 MHz system clock down to a 25 MHz pixel tick and generates 640x480@60 timing counters. It issues pixel coordinates to the upstream pixel source (framebuffer or renderer) and aligns the returned colour with delayed sync/blank so pins change together.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, horizontal sync width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIX_LAT, 1, upstream colour latency in pixel ticks, legal 0..4
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- pixel_x  out  10  current horizontal counter (combinational from counter)
- pixel_y  out  10  current vertical counter
- pixel_req  out  1  high when (pixel_x, pixel_y) is in the active area
- rgb_in  in  24  {R,G,B} for the coordinate issued PIX_LAT ticks earlier
- h_sync  out  1  horizontal sync, active-low
- v_sync  out  1  vertical sync, active-low
- red_out, green_out, blue_out  out  8 each  colour to DAC
- sync_n_out  out  1  composite sync to DAC, constant 0
- clk_out  out  1  25 MHz pixel clock to DAC
- blank_out  out  1  1 = active video, 0 = blanked
- frame_start  out  1  one-clk pulse at start of each frame

## Operation
- pix_en register toggles every clk edge; reset value 0. clk_out = pix_en.
- A "tick" is a clk edge at which pix_en was 1. All counters, delay line and output registers update only on ticks.
- h_cnt 0..H_TOTAL-1 (H_TOTAL = 800); wraps to 0 on tick at H_TOTAL-1, and v_cnt increments. v_cnt 0..V_TOTAL-1 (525), wraps to 0 when both at max.
- active = h_cnt < H_ACTIVE and v_cnt < V_ACTIVE. pixel_x = h_cnt, pixel_y = v_cnt, pixel_req = active.
- hs_raw low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751]; vs_raw low for v_cnt in [490,491].
- {active, hs_raw, vs_raw} pass through a PIX_LAT-stage shift register (wire when PIX_LAT=0), stage reset value {0,1,1}.
- Output register on tick: h_sync, v_sync, blank_out from delay-line tail; colour = delayed active ? rgb_in : 0 (rgb_in ignored while blanked).
- frame_start = 1 for exactly the one clk following the tick at which counters move to (0,0); reset value 0.
- Widths: counters 10 bits; no arithmetic beyond compare and increment; counters never exceed max.

## Timing
- Reset values: counters 0, pix_en 0, clk_out 0, h_sync 1, v_sync 1, colour 0, blank_out 0, frame_start 0, pixel_x/y 0, pixel_req 1.
- After reset release: first edge sets pix_en=1; second edge is first tick (counters 0->1).
- Coordinate held during tick period n; rgb_in must be stable at tick n+PIX_LAT; pins show that pixel from tick n+PIX_LAT for one tick (2 clk). Sync/blank/colour latency from counter = PIX_LAT+1 ticks, identical for all pins.
- Pins change as clk_out falls; DAC samples on clk_out rise, one clk later (data centred).
- Line = 1600 clk, frame = 840000 clk; h_sync low 192 clk; v_sync low 3200 clk.
- Reset asserted mid-frame: all outputs take reset values asynchronously; timing restarts from (0,0) exactly as after power-up.

## Test plan
- Reset held low, clk running -> all outputs at reset values listed; release -> h_cnt reaches 1 on second clk edge.
- Run one line, PIX_LAT=1 -> h_sync falls 657 ticks after counter leaves 0 (656 + 1 latency), stays low 192 clk, period 1600 clk.
- Run one frame -> v_sync low for exactly 2 lines starting line 490 (+1 tick latency); frame_start pulses every 840000 clk, 1 clk wide.
- Model upstream as rgb_in = {x[7:0], y[7:0], 8'hA5} delayed PIX_LAT=2 -> red_out at pin equals pixel x it belongs to while blank_out=1; all colour 0 whenever blank_out=0, even with rgb_in=24'hFFFFFF.
- blank_out high exactly 640 ticks per line, for lines 0..479 only; pixel_req high exactly on same coordinates 2 ticks (PIX_LAT+1) earlier.
- Assert reset at line 200, x=300 for 3 clk -> outputs immediately reset values; after release, next frame_start occurs 840000 clk later.
